fp16_mul_arbiter: RTL
=====================

// Module: fp16_mul_arbiter
// PURPOSE
//   Shares one pipelined fp16 multiplier (multiplier_fp16) among N_REQ SFU requesters.
//   - Round-robin arbitration; at most one multiply issued per cycle.
//   - Operand pairs are tagged with the requester index.
//   - Each result is routed back to its originator with a one-cycle valid pulse.
//   - Sits between the SFU lanes (Acc_mul-style squaring loops, exp/norm units) and the single multiplier.
// PARAMETERS
//   DATA_W   16  operand/result width (fp16 bit pattern, treated opaquely)
//   N_REQ    4   number of requesters, 2..16
//   MUL_LAT  3   multiplier latency in cycles, 1..8: operands driven in cycle c -> mul_res valid in cycle c+MUL_LAT
// PORTS
//   clk         in   1              clock, rising edge
//   rst_n       in   1              reset: asynchronous, active-low
//   req_valid   in   N_REQ          requester i has an operand pair
//   req_op_a    in   N_REQ*DATA_W   operand a, requester i in bits [i*DATA_W +: DATA_W]
//   req_op_b    in   N_REQ*DATA_W   operand b, same packing
//   req_ready   out  N_REQ          one-hot grant; handshake = req_valid[i] & req_ready[i]
//   resp_valid  out  N_REQ          one-hot, 1-cycle pulse: resp_data belongs to requester i
//   resp_data   out  DATA_W         product, shared by all requesters
//   mul_valid   out  1              mul_op_a/b hold a new issue this cycle
//   mul_op_a    out  DATA_W         multiplier operand a (registered)
//   mul_op_b    out  DATA_W         multiplier operand b (registered)
//   mul_res     in   DATA_W         multiplier result
//   busy        out  1              at least one multiply in flight or a response pending
// BEHAVIOUR
// - Reset values:
//   - req_ready, resp_valid, mul_valid, busy = 0; mul_op_a/b, resp_data = 0.
//   - RR pointer = 0; tag pipeline fully invalid.
// - Arbitration:
//   - Combinational: req_ready = one-hot of the first set req_valid bit searching ptr, ptr+1, ..., wrapping mod N_REQ.
//   - req_ready = 0 when no req_valid is set.
//   - No requester may see ready unless its own valid is high.
//   - On a handshake to index g, ptr <= (g+1) mod N_REQ. Otherwise ptr holds.
//   - Starvation bound: a continuously asserted requester is granted within N_REQ cycles.
// - Issue, handshake in cycle t:
//   - At the edge ending t: mul_op_a/b <= req_op_a/b[g]; mul_valid <= 1.
//   - Tag stage 0 <= {1, g}.
//   - Without a handshake: mul_valid <= 0, tag stage 0 <= invalid, mul_op_a/b hold their last values.
// - Tag pipeline: MUL_LAT+1 stages {valid, idx[$clog2(N_REQ)-1:0]}, shifting every cycle with no stall.
//   Stage MUL_LAT aligns with the cycle mul_res is valid for that issue.
// - Response:
//   - If stage MUL_LAT is valid in cycle c: at the edge ending c, resp_data <= mul_res and resp_valid <= onehot(idx).
//   - Otherwise resp_valid <= 0 and resp_data holds.
//   - Handshake cycle t -> resp_valid high in cycle t+MUL_LAT+2 (5 for defaults).
// - Requesters cannot backpressure responses; they must sample resp_valid/resp_data in the pulse cycle.
// - Throughput: 1 issue/cycle sustained; back-to-back issues from any mix of requesters give back-to-back responses in issue order.
// - busy = OR of all tag-stage valids OR resp_valid (registered terms only).
// - Width rules:
//   - Products pass through unmodified; no rounding or saturation here.
//   - The index field uses $clog2(N_REQ) bits; N_REQ that is not a power of two wraps at N_REQ-1 -> 0.
// - Simultaneous events: issue and response in the same cycle are independent; both take effect.
// - Reset mid-operation: all in-flight tags are discarded.
//   - No resp_valid may follow reset deassertion until a new handshake completes MUL_LAT+2 cycles later.
// - req_valid may drop without a handshake; the grant then moves on the same cycle, combinationally.
// TESTING
// - Single request: req_valid=0001, op_a=op_b=16'h4000 (2.0); mul model returns 16'h4400.
//   -> req_ready=0001 same cycle; resp_valid=0001 exactly 5 cycles later with resp_data=16'h4400; busy low afterwards.
// - All four requesters valid continuously for 8 cycles, starting from ptr=0.
//   -> grants in order 0,1,2,3,0,1,2,3; responses in the same order, one per cycle, each carrying its own operands' product.
// - Requesters 1 and 3 valid, ptr=2 -> grant 3 first, then 1; requester 1 is never skipped twice.
// - Back-to-back issue alternating 0/2 with distinct operands (3.0*3.0=16'h4880, 1.5*2.0=16'h4200).
//   -> resp_valid pulses 0001,0100,... with the matching data and no gaps.
// - Assert rst_n low for 1 cycle with 3 multiplies in flight.
//   -> outputs return to reset values immediately; no resp_valid for the flushed tags; ptr=0.
// - Re-run with MUL_LAT=1 and N_REQ=3.
//   -> latency is 3 cycles; grant wraps 2 -> 0.

Source files
------------

// File: rtl/fp16_mul_arbiter_if.sv
// Requester-side bus of the shared fp16 multiplier: operand requests in, tagged responses out.
interface fp16_mul_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int N_REQ  = 4
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_op_a;
    logic [N_REQ*DATA_W-1:0] req_op_b;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]       resp_data;

    modport master (
        output req_valid, req_op_a, req_op_b,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_op_a, req_op_b,
        output req_ready, resp_valid, resp_data
    );
endinterface

// File: rtl/fp16_mul_arbiter.sv
// Round-robin sharing of one pipelined fp16 multiplier among N_REQ requesters;
// each issue carries its requester index down a tag pipeline so the product returns to its owner.
module fp16_mul_arbiter #(
    parameter int DATA_W  = 16,
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fp16_mul_arbiter_if.slave      bus,
    output logic                   mul_valid,
    output logic [DATA_W-1:0]      mul_op_a,
    output logic [DATA_W-1:0]      mul_op_b,
    input  logic [DATA_W-1:0]      mul_res,
    output logic                   busy
);
    localparam int IDX_W = $clog2(N_REQ);
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [IDX_W:0]   cand_t;

    idx_t              ptr;
    idx_t              grant_idx;
    idx_t              ptr_next;
    logic              grant_any;
    cand_t             cand;
    logic [N_REQ-1:0]  ready;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    logic [MUL_LAT:0]  tag_v;
    idx_t              tag_idx [MUL_LAT+1];
    logic [N_REQ-1:0]  resp_valid_q;
    logic [DATA_W-1:0] resp_data_q;

    // Search ptr, ptr+1, ... modulo N_REQ; the wide candidate avoids overflow at N_REQ = 16.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + cand_t'(k);
            if (cand >= cand_t'(N_REQ))
                cand = cand - cand_t'(N_REQ);
            if (!grant_any && bus.req_valid[cand[IDX_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        ready = '0;
        if (grant_any)
            ready[grant_idx] = 1'b1;
    end

    assign ptr_next = (grant_idx == idx_t'(N_REQ-1)) ? '0 : grant_idx + idx_t'(1);
    assign sel_a    = bus.req_op_a[int'(grant_idx)*DATA_W +: DATA_W];
    assign sel_b    = bus.req_op_b[int'(grant_idx)*DATA_W +: DATA_W];

    assign bus.req_ready  = ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign busy           = (|tag_v) | (|resp_valid_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            mul_valid    <= 1'b0;
            mul_op_a     <= '0;
            mul_op_b     <= '0;
            tag_v        <= '0;
            for (int k = 0; k <= MUL_LAT; k++)
                tag_idx[k] <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            mul_valid  <= grant_any;
            tag_v      <= {tag_v[MUL_LAT-1:0], grant_any};
            tag_idx[0] <= grant_idx;
            for (int k = 1; k <= MUL_LAT; k++)
                tag_idx[k] <= tag_idx[k-1];
            if (grant_any) begin
                ptr      <= ptr_next;
                mul_op_a <= sel_a;
                mul_op_b <= sel_b;
            end
            // The last tag stage lines up with the cycle mul_res belongs to that issue.
            resp_valid_q <= '0;
            if (tag_v[MUL_LAT]) begin
                resp_valid_q[tag_idx[MUL_LAT]] <= 1'b1;
                resp_data_q                    <= mul_res;
            end
        end
    end
endmodule
